// File: rtl/beam_power_integrator_pkg.sv
// Shared beamformer constants and helpers.
// Used by the adder tree, the D-CFIR stages and the beam power integrator.
//   DW   : signed width of one real or imaginary sample component
//   PW   : unsigned width of one power value (|z|^2 peaks at 2^31)
//   KMAX : largest integration window exponent (window = 2^KMAX samples)
//   AW   : accumulator width, wide enough for 2^KMAX full-scale powers
package bf_pkg;

  localparam int DW   = 16;
  localparam int PW   = 32;
  localparam int KMAX = 10;
  localparam int AW   = PW + KMAX;
  localparam int KW   = 4;          // width of the win_log2 control field
  localparam int CW   = KMAX + 1;   // sample counter width, holds 2^KMAX

  // Window exponents above KMAX fall back to the longest supported window.
  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
    if (k > KW'(KMAX)) begin
      return KW'(KMAX);
    end
    return k;
  endfunction

endpackage

// File: rtl/beam_power_integrator_mag_sq.sv
// complex_mag_sq: two-stage |z|^2 pipeline.
//   stage 1 registers re^2 and im^2, stage 2 registers their sum.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flush              drops every sample currently in the pipeline and
//                      the one presented this cycle
//   in_real, in_imag   signed complex sample
//   in_valid           sample qualifier
//   out_pwr, out_valid unsigned power and its qualifier, two edges later
module complex_mag_sq
  import bf_pkg::*;
#(
  parameter int W  = DW,
  parameter int OW = PW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic signed [W-1:0] in_real,
  input  logic signed [W-1:0] in_imag,
  input  logic                in_valid,
  output logic [OW-1:0]       out_pwr,
  output logic                out_valid
);

  // Sign-extend before multiplying so the full 2W-bit product is kept.
  logic signed [2*W-1:0] re_prod;
  logic signed [2*W-1:0] im_prod;
  assign re_prod = (2*W)'(in_real) * (2*W)'(in_real);
  assign im_prod = (2*W)'(in_imag) * (2*W)'(in_imag);

  logic [2*W-1:0] re_sq_reg;
  logic [2*W-1:0] im_sq_reg;
  logic           sq_valid_reg;
  logic [OW-1:0]  pwr_reg;
  logic           pwr_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      re_sq_reg     <= '0;
      im_sq_reg     <= '0;
      sq_valid_reg  <= 1'b0;
      pwr_reg       <= '0;
      pwr_valid_reg <= 1'b0;
    end else begin
      if (in_valid) begin
        // Squares are never negative, so they are kept unsigned.
        re_sq_reg <= re_prod;
        im_sq_reg <= im_prod;
      end
      if (sq_valid_reg) begin
        pwr_reg <= OW'(re_sq_reg) + OW'(im_sq_reg);
      end
      sq_valid_reg  <= in_valid && !flush;
      pwr_valid_reg <= sq_valid_reg && !flush;
    end
  end

  assign out_pwr   = pwr_reg;
  assign out_valid = pwr_valid_reg;

endmodule

// File: rtl/beam_power_integrator.sv
// beam_power_integrator: average beam power over a 2^k-sample window.
// Ports:
//   CLK, rst             clock, synchronous active-high reset
//   din_real, din_imag   signed beam sample from the final adder tree
//   din_valid            sample qualifier
//   win_log2             window exponent k, clamped to KMAX, latched per window
//   threshold            detection threshold, sampled when a window completes
//   clear                flushes window, pipeline, detection and peak state
//   pwr_out              average power of the last completed window
//   pwr_valid            one-cycle strobe when pwr_out updates
//   det_flag             pwr_out >= threshold, held between windows
//   pwr_peak             largest pwr_out since rst/clear
//   win_busy             a window is partially accumulated
module beam_power_integrator
  import bf_pkg::*;
(
  input  logic                 CLK,
  input  logic                 rst,
  input  logic signed [DW-1:0] din_real,
  input  logic signed [DW-1:0] din_imag,
  input  logic                 din_valid,
  input  logic [KW-1:0]        win_log2,
  input  logic [PW-1:0]        threshold,
  input  logic                 clear,
  output logic [PW-1:0]        pwr_out,
  output logic                 pwr_valid,
  output logic                 det_flag,
  output logic [PW-1:0]        pwr_peak,
  output logic                 win_busy
);

  logic [PW-1:0] p_pwr;
  logic          p_valid;

  complex_mag_sq #(
    .W  (DW),
    .OW (PW)
  ) u_mag_sq (
    .clk       (CLK),
    .rst       (rst),
    .flush     (clear),
    .in_real   (din_real),
    .in_imag   (din_imag),
    .in_valid  (din_valid),
    .out_pwr   (p_pwr),
    .out_valid (p_valid)
  );

  logic [AW-1:0] acc_reg;
  logic [CW-1:0] cnt_reg;
  logic [KW-1:0] k_act_reg;
  logic [PW-1:0] pwr_out_reg;
  logic          pwr_valid_reg;
  logic          det_flag_reg;
  logic [PW-1:0] pwr_peak_reg;
  logic          win_busy_reg;

  logic [KW-1:0] k_use;
  logic [AW-1:0] acc_sum;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] win_len;
  logic          win_done;
  logic [PW-1:0] avg_next;

  always_comb begin
    // An empty window takes its length from the live control input; once
    // started, the length latched on its first sample stays in force.
    k_use    = (cnt_reg == '0) ? clamp_k(win_log2) : k_act_reg;
    acc_sum  = acc_reg + AW'(p_pwr);
    cnt_inc  = cnt_reg + CW'(1);
    win_len  = CW'(1) << k_use;
    win_done = p_valid && (cnt_inc == win_len);
    // The average never exceeds 2^31, so truncation to PW bits is exact.
    avg_next = PW'(acc_sum >> k_use);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      k_act_reg     <= '0;
      pwr_out_reg   <= '0;
      pwr_valid_reg <= 1'b0;
      det_flag_reg  <= 1'b0;
      pwr_peak_reg  <= '0;
      win_busy_reg  <= 1'b0;
    end else if (clear) begin
      // pwr_out deliberately keeps the last completed result.
      acc_reg       <= '0;
      cnt_reg       <= '0;
      pwr_valid_reg <= 1'b0;
      det_flag_reg  <= 1'b0;
      pwr_peak_reg  <= '0;
      win_busy_reg  <= 1'b0;
    end else begin
      pwr_valid_reg <= 1'b0;
      if (p_valid) begin
        k_act_reg <= k_use;
        if (win_done) begin
          // Completing here leaves cnt at zero, so the very next sample
          // opens the following window without a dead cycle.
          pwr_out_reg   <= avg_next;
          pwr_valid_reg <= 1'b1;
          det_flag_reg  <= (avg_next >= threshold);
          if (avg_next > pwr_peak_reg) begin
            pwr_peak_reg <= avg_next;
          end
          acc_reg      <= '0;
          cnt_reg      <= '0;
          win_busy_reg <= 1'b0;
        end else begin
          acc_reg      <= acc_sum;
          cnt_reg      <= cnt_inc;
          win_busy_reg <= 1'b1;
        end
      end
    end
  end

  assign pwr_out   = pwr_out_reg;
  assign pwr_valid = pwr_valid_reg;
  assign det_flag  = det_flag_reg;
  assign pwr_peak  = pwr_peak_reg;
  assign win_busy  = win_busy_reg;

endmodule

// File: tb/tb_beam_power_integrator.sv
// Self-checking bench for beam_power_integrator: directed scenarios plus a
// randomized run checked against a window-level reference model.
module tb_beam_power_integrator;
  import bf_pkg::*;

  logic                 CLK = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] din_real;
  logic signed [DW-1:0] din_imag;
  logic                 din_valid;
  logic [KW-1:0]        win_log2;
  logic [PW-1:0]        threshold;
  logic                 clear;
  logic [PW-1:0]        pwr_out;
  logic                 pwr_valid;
  logic                 det_flag;
  logic [PW-1:0]        pwr_peak;
  logic                 win_busy;

  beam_power_integrator dut (
    .CLK       (CLK),
    .rst       (rst),
    .din_real  (din_real),
    .din_imag  (din_imag),
    .din_valid (din_valid),
    .win_log2  (win_log2),
    .threshold (threshold),
    .clear     (clear),
    .pwr_out   (pwr_out),
    .pwr_valid (pwr_valid),
    .det_flag  (det_flag),
    .pwr_peak  (pwr_peak),
    .win_busy  (win_busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    longint unsigned pwr;
    bit              det;
    longint unsigned peak;
    int              cyc;
  } res_t;

  res_t obs[$];
  res_t exp_q[$];

  // Result monitor: one line per completed window.
  always @(negedge CLK) begin
    if (pwr_valid === 1'b1) begin
      obs.push_back('{pwr_out, det_flag, pwr_peak, cyc});
      $display("cycle %0d result pwr=%0d det=%0b peak=%0d busy=%0b",
               cyc, pwr_out, det_flag, pwr_peak, win_busy);
    end
  end

  // Reference model: gathers valid samples into windows of 2^k, where k is
  // taken when a window opens, and predicts each window's average.
  longint unsigned m_sum, m_peak;
  int m_cnt, m_k;

  task automatic model_clear();
    m_sum = 0; m_cnt = 0; m_peak = 0;
  endtask

  task automatic model_sample(input int re, input int im);
    longint unsigned p, avg;
    res_t r;
    p = longint'(re * re) + longint'(im * im);
    if (m_cnt == 0) m_k = (int'(win_log2) > KMAX) ? KMAX : int'(win_log2);
    m_sum += p;
    m_cnt++;
    if (m_cnt == (1 << m_k)) begin
      avg = m_sum >> m_k;
      if (avg > m_peak) m_peak = avg;
      r.pwr = avg; r.det = (avg >= longint'(threshold)); r.peak = m_peak; r.cyc = 0;
      exp_q.push_back(r);
      m_sum = 0; m_cnt = 0;
    end
  endtask

  // Drive one cycle of input (called at a falling edge), update the model.
  task automatic step(input int re, input int im, input bit v);
    din_real  = re[DW-1:0];
    din_imag  = im[DW-1:0];
    din_valid = v;
    if (rst || clear) model_clear();
    else if (v) model_sample(re, im);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    total++; if (pwr_out !== '0)    begin bad++; $display("FAIL reset_pwr_out got=%0d want=0", pwr_out); end
    total++; if (pwr_valid !== 1'b0) begin bad++; $display("FAIL reset_pwr_valid got=%0b want=0", pwr_valid); end
    total++; if (det_flag !== 1'b0)  begin bad++; $display("FAIL reset_det got=%0b want=0", det_flag); end
    total++; if (pwr_peak !== '0)   begin bad++; $display("FAIL reset_peak got=%0d want=0", pwr_peak); end
    total++; if (win_busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%0b want=0", win_busy); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic_window();
    int n;
    obs.delete(); exp_q.delete();
    win_log2 = 4'd2; threshold = 32'd20;
    repeat (3) step(3, 4, 1'b1);
    n = cyc;
    step(3, 4, 1'b1);
    idle(6);
    total++; if (obs.size() !== 1) begin bad++; $display("FAIL basic_count got=%0d want=1", obs.size()); end
    if (obs.size() > 0) begin
      total++; if (obs[0].pwr !== 25) begin bad++; $display("FAIL basic_pwr got=%0d want=25", obs[0].pwr); end
      total++; if (obs[0].det !== 1'b1) begin bad++; $display("FAIL basic_det got=%0b want=1", obs[0].det); end
      total++; if (obs[0].cyc !== n + 3) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", obs[0].cyc, n + 3); end
      total++; if (obs[0].peak !== 25) begin bad++; $display("FAIL basic_peak got=%0d want=25", obs[0].peak); end
    end
  endtask

  task automatic test_full_scale();
    int n0;
    obs.delete(); exp_q.delete();
    win_log2 = 4'd0; threshold = 32'h8000_0000;
    n0 = cyc;
    repeat (6) step(-32768, -32768, 1'b1);
    idle(6);
    total++; if (obs.size() !== 6) begin bad++; $display("FAIL full_count got=%0d want=6", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      total++;
      if (obs[i].pwr !== 64'd2147483648 || obs[i].peak !== 64'd2147483648 ||
          obs[i].det !== 1'b1 || obs[i].cyc !== n0 + 3 + i) begin
        bad++;
        $display("FAIL full_result[%0d] got pwr=%0d peak=%0d det=%0b cyc=%0d want pwr=2147483648 peak=2147483648 det=1 cyc=%0d",
                 i, obs[i].pwr, obs[i].peak, obs[i].det, obs[i].cyc, n0 + 3 + i);
      end
    end
  endtask

  int  b_first, b_bad;
  bit  b_got;
  task automatic bubble_step(input bit v);
    if (v) step(1, 1, 1'b1); else step(0, 0, 1'b0);
    if (pwr_valid === 1'b1) begin
      b_got = 1'b1;
      if (win_busy !== 1'b0) b_bad++;
    end else if (!b_got && cyc >= b_first + 3 && win_busy !== 1'b1) begin
      b_bad++;
    end
  endtask

  task automatic test_bubbles();
    obs.delete(); exp_q.delete();
    win_log2 = 4'd3; threshold = 32'd3;
    total++; if (win_busy !== 1'b0) begin bad++; $display("FAIL bubble_busy_idle got=%0b want=0", win_busy); end
    b_first = cyc; b_bad = 0; b_got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bubble_step(1'b1);
      repeat ($urandom_range(1, 2)) bubble_step(1'b0);
    end
    repeat (6) bubble_step(1'b0);
    total++; if (b_bad !== 0) begin bad++; $display("FAIL bubble_busy_track got=%0d bad cycles want=0", b_bad); end
    total++; if (obs.size() !== 1) begin bad++; $display("FAIL bubble_count got=%0d want=1", obs.size()); end
    if (obs.size() > 0) begin
      total++; if (obs[0].pwr !== 2 || obs[0].det !== 1'b0) begin bad++; $display("FAIL bubble_result got pwr=%0d det=%0b want pwr=2 det=0", obs[0].pwr, obs[0].det); end
    end
  endtask

  task automatic test_k_change();
    obs.delete(); exp_q.delete();
    win_log2 = 4'd2; threshold = 32'd0;
    repeat (2) step($urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100, 1'b1);
    idle(2);
    win_log2 = 4'd0;
    repeat (4) step($urandom_range(0, 200) - 100, $urandom_range(0, 200) - 100, 1'b1);
    idle(6);
    total++; if (obs.size() !== 3 || exp_q.size() !== 3) begin bad++; $display("FAIL kchg_count got=%0d want=3 (model %0d)", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs[i].pwr !== exp_q[i].pwr || obs[i].det !== exp_q[i].det || obs[i].peak !== exp_q[i].peak) begin
        bad++;
        $display("FAIL kchg_result[%0d] got pwr=%0d det=%0b peak=%0d want pwr=%0d det=%0b peak=%0d",
                 i, obs[i].pwr, obs[i].det, obs[i].peak, exp_q[i].pwr, exp_q[i].det, exp_q[i].peak);
      end
    end
  endtask

  task automatic test_clamp_clear();
    logic [PW-1:0] prev;
    obs.delete(); exp_q.delete();
    win_log2 = 4'd15; threshold = 32'd0;
    prev = pwr_out;
    repeat (500) step($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, 1'b1);
    idle(3);
    total++; if (obs.size() !== 0 || win_busy !== 1'b1) begin bad++; $display("FAIL clamp_partial got results=%0d busy=%0b want 0 and 1", obs.size(), win_busy); end
    clear = 1'b1;
    step(32767, 32767, 1'b1);
    clear = 1'b0;
    total++; if (pwr_peak !== '0)     begin bad++; $display("FAIL clear_peak got=%0d want=0", pwr_peak); end
    total++; if (det_flag !== 1'b0)   begin bad++; $display("FAIL clear_det got=%0b want=0", det_flag); end
    total++; if (pwr_out !== prev)    begin bad++; $display("FAIL clear_pwr_hold got=%0d want=%0d", pwr_out, prev); end
    total++; if (win_busy !== 1'b0)   begin bad++; $display("FAIL clear_busy got=%0b want=0", win_busy); end
    repeat (1023) step(0, 2, 1'b1);
    idle(4);
    total++; if (obs.size() !== 0) begin bad++; $display("FAIL clamp_early got results=%0d want=0", obs.size()); end
    step(0, 2, 1'b1);
    idle(6);
    total++; if (obs.size() !== 1) begin bad++; $display("FAIL clamp_count got=%0d want=1", obs.size()); end
    if (obs.size() > 0) begin
      total++; if (obs[0].pwr !== 4 || obs[0].peak !== 4 || obs[0].det !== 1'b1) begin bad++; $display("FAIL clamp_result got pwr=%0d peak=%0d det=%0b want 4 4 1", obs[0].pwr, obs[0].peak, obs[0].det); end
    end
  endtask

  task automatic test_reset_mid();
    obs.delete(); exp_q.delete();
    win_log2 = 4'd3; threshold = 32'd0;
    repeat (2) step(5, 5, 1'b1);
    rst = 1'b1;
    step(5, 5, 1'b1);
    rst = 1'b0;
    total++;
    if (pwr_out !== '0 || pwr_valid !== 1'b0 || det_flag !== 1'b0 || pwr_peak !== '0 || win_busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_outputs got pwr=%0d valid=%0b det=%0b peak=%0d busy=%0b want all 0",
               pwr_out, pwr_valid, det_flag, pwr_peak, win_busy);
    end
    idle(3);
    total++; if (obs.size() !== 0) begin bad++; $display("FAIL rstmid_leak got results=%0d want=0", obs.size()); end
    win_log2 = 4'd1;
    repeat (2) step(2, 0, 1'b1);
    idle(6);
    total++; if (obs.size() !== 1) begin bad++; $display("FAIL rstmid_count got=%0d want=1", obs.size()); end
    if (obs.size() > 0) begin
      total++; if (obs[0].pwr !== 4 || obs[0].det !== 1'b1) begin bad++; $display("FAIL rstmid_result got pwr=%0d det=%0b want pwr=4 det=1", obs[0].pwr, obs[0].det); end
    end
  endtask

  task automatic test_random();
    obs.delete(); exp_q.delete();
    for (int s = 0; s < 6; s++) begin
      win_log2  = 4'($urandom_range(0, 4));
      threshold = $urandom_range(0, 32'h4000_0000);
      for (int i = 0; i < 60; i++) begin
        step($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
             ($urandom_range(0, 3) != 0));
      end
      idle(4);
    end
    idle(4);
    total++; if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs[i].pwr !== exp_q[i].pwr || obs[i].det !== exp_q[i].det || obs[i].peak !== exp_q[i].peak) begin
        bad++;
        $display("FAIL rand_result[%0d] got pwr=%0d det=%0b peak=%0d want pwr=%0d det=%0b peak=%0d",
                 i, obs[i].pwr, obs[i].det, obs[i].peak, exp_q[i].pwr, exp_q[i].det, exp_q[i].peak);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; din_real = '0; din_imag = '0; din_valid = 1'b0;
    win_log2 = '0; threshold = '0;
    model_clear();
    m_k = 0;
    @(negedge CLK);
    test_reset();
    test_basic_window();
    test_full_scale();
    test_bubbles();
    test_k_change();
    test_clamp_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/beam_power_integrator.md
Name: beam_power_integrator

Overview:
- Sits directly downstream of the 4-channel VMM + D-CFIR beamformer's final complex adder tree.
- Consumes the 16-bit complex beam output, computes instantaneous power |z|^2, integrates over a programmable 2^k-sample window and emits the average power once per window.
- Each result is compared against a threshold (detection flag) and feeds a peak-hold register for beam scanning/calibration.

Parameters:
- DW, 16, signed width of din_real/din_imag.
- PW, 32, unsigned power width; DW*2 is sufficient for the max of 2^31.
- KMAX, 10, maximum win_log2; larger requests clamp to KMAX.
- AW, 42, accumulator width, equal to PW+KMAX.

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- din_real  in  DW  signed real part of beam sample (from output_z_real_final_adder_level2).
- din_imag  in  DW  signed imaginary part of beam sample (from output_z_imag_final_adder_level2).
- din_valid  in  1  sample qualifier; tie high for continuous streaming.
- win_log2  in  4  window length exponent k; window is 2^k samples.
- threshold  in  PW  detection threshold, unsigned.
- clear  in  1  synchronous flush of window and peak state.
- pwr_out  out  PW  average power of last completed window.
- pwr_valid  out  1  one-cycle strobe when pwr_out updates.
- det_flag  out  1  pwr_out >= threshold, held between windows.
- pwr_peak  out  PW  maximum pwr_out since rst/clear.
- win_busy  out  1  high while a window is partially accumulated.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - rst=1 at an edge zeroes all state and all outputs: pwr_out, pwr_valid, det_flag, pwr_peak, win_busy, accumulator, sample counter, pipeline valids.
  - rst has priority over clear and din_valid.
- Pipeline:
  - Edge E0 (sample with din_valid=1): register re^2 and im^2. Each is signed DWxDW; the result is non-negative, max 2^30.
  - Edge E1: p = re^2 + im^2, unsigned PW bits, max 2^31, no overflow.
  - Edge E2: accumulate p.
  - Each stage carries a valid bit; bubbles (din_valid=0) propagate and never accumulate.
- Window control:
  - Counter cnt counts accumulated samples.
  - On the first valid accumulation of a window, latch k_act = min(win_log2, KMAX); win_busy goes high.
  - win_log2 changes mid-window are ignored until the next window starts.
- Window completion:
  - Triggered on the E2 edge of sample number 2^k_act.
  - pwr_out <= (acc + p) >> k_act, truncated to PW bits; this is exact because the max is 2^31.
  - pwr_valid <= 1 for exactly one cycle; acc <= 0; cnt <= 0; win_busy <= 0.
  - Latency: last sample presented in cycle n gives pwr_valid high in cycle n+3.
- k_act=0: every valid sample produces a result. Continuous valid input then gives pwr_valid high every cycle after 3 cycles of latency.
- Detection and peak hold, both updated on the same edge as pwr_valid:
  - det_flag <= (new pwr_out >= threshold), with threshold sampled at that edge.
  - pwr_peak <= max(pwr_peak, new pwr_out).
- clear=1:
  - Flushes acc, cnt, the pipeline valid bits, and sets win_busy=0, pwr_peak=0, det_flag=0.
  - pwr_out holds its last value; pwr_valid=0 that cycle.
  - Any sample presented in the same cycle as clear is discarded.
  - Samples in flight are lost; the next window starts with the first valid sample after clear deasserts.
- Back-to-back windows: the first sample of window N+1 can accumulate on the same edge that completes window N. No dead cycle is permitted.
- Accumulator never overflows: 2^KMAX * 2^31 < 2^AW.

Decomposition:
- Package bf_pkg:
  - Constants DW, PW, KMAX, AW.
  - Clamp function for win_log2.
  - Shared with the adder and D-CFIR stages.
- Sub-module complex_mag_sq:
  - Two-stage pipeline (square registers, then sum) with in_valid/out_valid.
  - Reusable for per-channel power monitors on the D-CFIR outputs.
- The top level holds the window counter, accumulator, detect and peak logic.

Test Plan:
- Basic window: k=2, din=(3,4) valid for 4 cycles -> single pwr_valid 3 cycles after last sample, pwr_out=25; threshold=20 -> det_flag=1.
- Full-scale: k=0, din=(-32768,-32768) continuous -> pwr_out=2147483648 every cycle; pwr_peak=2147483648; no wrap.
- Bubbles: k=3, 8 samples of (1,1) interleaved with din_valid=0 gaps -> exactly one result, pwr_out=2; win_busy high from first accumulation until result.
- Mid-window k change: k=2, after 2 samples set win_log2=0 -> window still completes after 4 samples. Next window uses k=0 (one result per sample).
- Clamp and clear:
  - win_log2=15 -> window length 1024.
  - Assert clear after 500 samples -> no result, pwr_peak=0, det_flag=0, pwr_out unchanged.
  - Next 1024 samples of (0,2) -> pwr_out=4.
- Reset mid-window: rst for 1 cycle during accumulation with threshold=0 -> all outputs 0. Following window of (2,0), k=1 -> pwr_out=4, det_flag=1.
